// File: rtl/key_pkg.sv
// Shared definitions for the key conditioning front end.
//
// Contents:
//   key_state_e          per-channel debounce FSM state
//   DEBOUNCE_CYCLES_DEF  default number of stable samples needed to accept a level
//   REPEAT_DELAY_DEF     default press-to-first-repeat delay (KEY_AUTOREPEAT_EN only)
//   REPEAT_PERIOD_DEF    default repeat interval (KEY_AUTOREPEAT_EN only)
//
// Build option: KEY_AUTOREPEAT_EN enables the auto-repeat constants.
package key_pkg;

  typedef enum logic [1:0] {
    StReleased   = 2'd0,
    StPressChk   = 2'd1,
    StPressed    = 2'd2,
    StReleaseChk = 2'd3
  } key_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REPEAT_DELAY_DEF  = 50000;
  localparam int unsigned REPEAT_PERIOD_DEF = 10000;
`endif

endpackage

// File: rtl/key_debounce_ch.sv
// Single key channel: 2-FF synchroniser, debounce counter and press/release FSM.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   key_n_i    raw asynchronous key, active-low
//   level_o    debounced level, 1 = pressed
//   press_o    one-cycle strobe on an accepted press (and on repeats if enabled)
//   release_o  one-cycle strobe on an accepted release
//
// Build option: KEY_AUTOREPEAT_EN adds RepeatDelay/RepeatPeriod and the repeat counter.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEF
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned RepeatDelay    = REPEAT_DELAY_DEF,
  parameter int unsigned RepeatPeriod   = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_W = $clog2(DebounceCycles + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DebounceCycles - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [1:0]       sync_q;  // [0] first stage, [1] second stage (active-low)
  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             sample;

  // Active-high synchronised key sample.
  assign sample = ~sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RepMax = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(RepeatDelay - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(RepeatPeriod - 1);

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_first_q;  // next repeat is the first one, so it waits RepeatDelay
  logic [RepW-1:0] rep_last;

  assign rep_last = rep_first_q ? RepDelayLast : RepPeriodLast;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= 2'b11;
      state_q     <= StReleased;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        StReleased: begin
          if (sample) begin
            state_q <= StPressChk;
            cnt_q   <= CntOne;
          end
        end
        StPressChk: begin
          if (!sample) begin
            state_q <= StReleased;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q     <= StPressed;
            level_q     <= 1'b1;
            press_q     <= 1'b1;
            cnt_q       <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPressed: begin
          if (!sample) begin
            state_q     <= StReleaseChk;
            cnt_q       <= CntOne;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
          end
`ifdef KEY_AUTOREPEAT_EN
          else if (rep_cnt_q == rep_last) begin
            press_q     <= 1'b1;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
          end else begin
            rep_cnt_q <= rep_cnt_q + RepW'(1);
          end
`endif
        end
        StReleaseChk: begin
          if (sample) begin
            // Release glitch: back to pressed without any strobe.
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q   <= StReleased;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce_pulse.sv
// Push-button front end: synchronises, debounces and edge-detects NUM_KEYS active-low keys,
// giving clean active-high levels and one-cycle press/release strobes.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   keys_n       raw asynchronous keys, active-low (0 = pressed)
//   key_level    debounced state, 1 = pressed
//   key_press    one-cycle strobe per accepted press
//   key_release  one-cycle strobe per accepted release
//
// Build option: KEY_AUTOREPEAT_EN adds REPEAT_DELAY/REPEAT_PERIOD and repeated key_press
// strobes while a key stays held.
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_ch #(
      .DebounceCycles(DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .RepeatDelay   (REPEAT_DELAY),
      .RepeatPeriod  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .key_n_i  (keys_n[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i])
    );
  end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
Front-end conditioning stage for the board push-buttons: synchronises, debounces and edge-detects NUM_KEYS active-low raw key inputs. Produces clean active-high levels plus one-cycle press/release strobes, which feed the keys interface of qspi_flash_tester (write, read, add, sub). It replaces direct use of raw pins, so downstream logic sees exactly one event per physical press.

Parameters:
NUM_KEYS, 5, number of independent key channels
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new level (minimum 2)
CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived localparam, not overridable

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
keys_n  input  NUM_KEYS  raw asynchronous keys, active-low (0 = pressed)
key_level  output  NUM_KEYS  debounced state, 1 = pressed
key_press  output  NUM_KEYS  one-cycle strobe on accepted press
key_release  output  NUM_KEYS  one-cycle strobe on accepted release

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high. All registers clear on a rising clk edge while rst=1.
- Reset values:
  - key_level=0, key_press=0, key_release=0.
  - Synchroniser flops = 1 (released).
  - Counters = 0.
  - FSM = RELEASED.
- Synchroniser: 2-FF per key on keys_n, then inverted to active-high sample s.
- Per-key FSM: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
  - RELEASED: s=1 -> PRESS_CHK, cnt=1.
  - PRESS_CHK: s=1 -> cnt++; s=0 -> RELEASED, cnt=0.
    - When cnt==DEBOUNCE_CYCLES-1 and s=1 -> PRESSED, key_level<=1, key_press<=1 for exactly one cycle, cnt=0.
  - PRESSED: s=0 -> RELEASE_CHK, cnt=1.
  - RELEASE_CHK: mirror of PRESS_CHK.
    - Accept -> RELEASED, key_level<=0, key_release<=1 for one cycle.
    - s=1 -> PRESSED (glitch rejected, no strobe).
- Latency: raw edge held stable -> key_press/key_release high at edge 2+DEBOUNCE_CYCLES (2 sync + count). key_level changes the same cycle as its strobe.
- Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- Channels are fully independent; simultaneous events on several keys give simultaneous strobes.
- key_press and key_release are never high together on one channel.
- rst mid-count: the count is discarded and the channel returns to RELEASED.
  - A key held through reset is re-accepted as a fresh press DEBOUNCE_CYCLES+2 cycles after rst deasserts.
- Outputs are registered; no combinational path from keys_n.

Optional Feature:
KEY_AUTOREPEAT_EN
- Defined:
  - Adds parameters REPEAT_DELAY (default 50000) and REPEAT_PERIOD (default 10000), both in clk cycles.
  - In PRESSED, a repeat counter runs. The first extra key_press strobe fires REPEAT_DELAY cycles after the accepted press, then one every REPEAT_PERIOD cycles while held.
  - Leaving PRESSED (entering RELEASE_CHK) clears the repeat counter.
  - No key_release is generated for repeats.
- Undefined:
  - Exactly one key_press per physical press.
  - Repeat counter logic is absent.

Decomposition:
- Package key_pkg:
  - FSM state encoding: RELEASED=2'd0, PRESS_CHK=2'd1, PRESSED=2'd2, RELEASE_CHK=2'd3.
  - Default constants DEBOUNCE_CYCLES_DEF and, for the optional feature, REPEAT_DELAY_DEF and REPEAT_PERIOD_DEF.
- Sub-module key_debounce_ch: single-channel synchroniser + counter + FSM (+ repeat logic). Instantiated NUM_KEYS times in a generate loop; the top is pure wiring.

Test Plan:
Bench conditions: 10 ns clk, DEBOUNCE_CYCLES=16, NUM_KEYS=5, macro undefined unless noted.
1. Clean press: keys_n[0] 1->0, held 40 cycles -> key_press[0] one pulse at edge 18 after the change; key_level[0]=1 from the same edge. Then release -> key_release[0] one pulse 18 edges after the rising edge; key_level[0]=0.
2. Bounce rejection: keys_n[4] low for 11 cycles, high 3, low 11, high -> key_press, key_release and key_level all remain 0 throughout.
3. Release glitch: key[1] accepted pressed, then keys_n[1] high for 8 cycles and low again -> key_level[1] stays 1, no key_release[1].
4. Reset mid-count: keys_n[2] low, rst=1 at cycle 10 for 1 cycle, key held -> key_press[2] 18 edges after rst deassert; all outputs 0 during reset.
5. Simultaneous: keys_n[3] and keys_n[1] fall on the same edge -> key_press[3] and key_press[1] asserted on the same cycle, other bits 0.
6. KEY_AUTOREPEAT_EN, REPEAT_DELAY=100, REPEAT_PERIOD=20, key[0] held 200 cycles after accept -> key_press[0] at accept, accept+100, +120, +140, +160, +180, +200 cycles; stops on release.
